trng32: RTL and testbench
=========================

# trng32

32-bit random-number source: an entropy core feeds a conditioning register that publishes a fresh 32-bit word `R` every enabled clock. It sits under the CSPRNG as its seed and reseed supplier. The default entropy core is a deterministic LFSR noise model, bit-exact and reproducible in simulation. An optional ring-oscillator bank mixes physical jitter in for silicon builds.

## Interface
- `SEED`, default 64'h0000_0000_0000_0001: noise-LFSR reset value; an all-zero value is replaced by 64'h1.
- `WARMUP`, default 8: number of enabled cycles before `valid` asserts; range 1..255.
- `USE_RO`, default 0: 0 selects the LFSR model only; 1 also mixes in the ring-oscillator bank.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `en  in  1`: enable; when high, all state advances one step per clock.
- `R  out  32`: random word, registered.
- `valid  out  1`: high once warm-up completes; stays high until reset.

## Operation
- Noise core, `s[63:0]`: right-shift Galois LFSR with mask 64'hD800_0000_0000_0000 (polynomial x^64+x^63+x^61+x^60+1).
  - Step: `s' = (s >> 1) ^ (s[0] ? MASK : 0)`.
  - The state can never become zero.
- Ring-oscillator bank (USE_RO=1 only):
  - 32 free-running 3-inverter ring oscillators, each kept with a keep/dont_touch attribute.
  - Each oscillator is sampled through a 2-flop synchronizer, giving `ro[31:0]`.
  - When USE_RO=0, `ro = 0` and the bank is not instantiated.
- Conditioning, on each enabled edge:
  - `R' = {R[30:0], R[31]} ^ s'[63:32] ^ s'[31:0] ^ ro`.
  - `s'` is the post-step LFSR value.
- Warm-up counter, 8 bits, saturating:
  - Increments on each enabled edge until it equals `WARMUP`.
  - `valid = (count == WARMUP)`, registered.
- With `en = 0`, `s`, `R`, the counter and `valid` all hold. The RO synchronizers keep running.
- Consumers should ignore `R` while `valid = 0`. `R` still updates during warm-up.

## Timing
- Reset values, asserted asynchronously on `rst_n` low: `R = 0`, `valid = 0`, counter = 0, `s = SEED` (or 1 if SEED = 0), RO synchronizer flops = 0.
- Reset release: a rising edge coinciding with deassertion does nothing. The first state step happens on the first edge with `rst_n = 1` and `en = 1`.
- Latency: `R` changes one clock after `en` is sampled high, i.e. one new word per enabled cycle.
- `valid` rises on the same edge that produces the `WARMUP`-th enabled word.
- Enable gaps do not reset the warm-up count.
- Reset asserted mid-stream: all outputs return to reset values immediately, without waiting for a clock edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n = 0` for 3 cycles -> `R = 32'h0`, `valid = 0`. Assert reset mid-cycle -> outputs clear before the next edge.
- Golden sequence (SEED = 1, USE_RO = 0, `en = 1`):
  - 1st enabled edge: `R = 32'hD800_0000`.
  - 2nd enabled edge: `R = 32'hDC00_0001`.
  - Continue for 100 words against a bench reference model; no mismatches allowed.
- Enable hold: toggle `en` low for 5 cycles mid-stream -> `R`, `valid` and the sequence position are unchanged; the sequence resumes exactly with the next word when `en` returns high.
- Warm-up (WARMUP = 8):
  - `valid` is 0 after 7 enabled edges and 1 after the 8th.
  - Inserting `en = 0` gaps delays `valid` by exactly the gap length.
- Zero seed: SEED = 0 -> output sequence is identical to the SEED = 1 sequence.
- Sanity over 10,000 words:
  - Every bit of `R` toggles at least once.
  - No two consecutive words are equal.
  - Each bit's ones-fraction lies within 0.45–0.55.

Source files
------------

// File: rtl/trng32.sv
// 32-bit random-number source: a 64-bit Galois LFSR noise core, optionally mixed with a
// ring-oscillator bank, feeds a rotating conditioning register with a saturating warm-up gate.
module trng32 #(
    parameter logic [63:0] SEED   = 64'h0000_0000_0000_0001,
    parameter int unsigned WARMUP = 8,
    parameter bit          USE_RO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] R,
    output logic        valid
);

    localparam logic [63:0] MASK      = 64'hD800_0000_0000_0000;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [63:0] SEED_INIT = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [7:0]  WARM      = 8'(WARMUP);

    logic [63:0] s_q;
    logic [63:0] s_d;
    logic [31:0] r_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        valid_d;
    logic [31:0] ro;

    always_comb begin
        s_d     = (s_q >> 1) ^ (s_q[0] ? MASK : 64'd0);
        r_d     = {R[30:0], R[31]} ^ s_d[63:32] ^ s_d[31:0] ^ ro;
        cnt_d   = (cnt_q == WARM) ? cnt_q : cnt_q + 8'd1;
        valid_d = (cnt_d == WARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= SEED_INIT;
            R     <= 32'd0;
            cnt_q <= 8'd0;
            valid <= 1'b0;
        end else if (en) begin
            s_q   <= s_d;
            R     <= r_d;
            cnt_q <= cnt_d;
            valid <= valid_d;
        end
    end

    if (USE_RO) begin : g_ro
        for (genvar i = 0; i < 32; i++) begin : g_osc
            // Free-running 3-inverter loop; attributes stop synthesis from collapsing it.
            (* keep = "true", dont_touch = "true" *) logic n0;
            (* keep = "true", dont_touch = "true" *) logic n1;
            (* keep = "true", dont_touch = "true" *) logic n2;
            logic [1:0] sync_q;

            assign n1 = ~n0;
            assign n2 = ~n1;
            assign n0 = ~n2;

            // Synchronizers run regardless of en.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], n2};
                end
            end

            assign ro[i] = sync_q[1];
        end
    end else begin : g_no_ro
        assign ro = 32'd0;
    end

endmodule

// File: tb/tb_trng32.sv
// Self-checking bench for trng32: golden words, enable hold, warm-up gating, zero seed,
// asynchronous reset and long-run bit statistics against a behavioural model.
module tb_trng32;

    localparam int unsigned WARMUP = 8;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] r1;
    logic        v1;
    logic [31:0] r0;
    logic        v0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] m_s;
    logic [31:0] m_r;
    int          m_cnt;

    trng32 #(.SEED(64'h1), .WARMUP(WARMUP), .USE_RO(1'b0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .R    (r1),
        .valid(v1)
    );

    trng32 #(.SEED(64'h0), .WARMUP(WARMUP), .USE_RO(1'b0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .R    (r0),
        .valid(v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s   = 64'h1;
        m_r   = 32'h0;
        m_cnt = 0;
    endtask

    // One clock; the model advances if the DUT will sample en=1 out of reset.
    task automatic step();
        logic [63:0] ns;
        if (en && rst_n) begin
            ns    = m_s / 2;
            if (m_s % 2 == 1) ns = ns ^ 64'hD800_0000_0000_0000;
            m_s   = ns;
            m_r   = ((m_r << 1) | (m_r >> 31)) ^ ns[63:32] ^ ns[31:0];
            m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic mv;
        mv = (m_cnt >= int'(WARMUP));
        chk({tag, "_R"}, {32'd0, r1}, {32'd0, m_r});
        chk({tag, "_valid"}, {63'd0, v1}, {63'd0, mv});
        chk({tag, "_R_seed0"}, {32'd0, r0}, {32'd0, m_r});
        chk({tag, "_valid_seed0"}, {63'd0, v0}, {63'd0, mv});
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] hold_r;
        logic [31:0] tog;
        int          nrep;
        int          ones [32];
        int          rise;
        bit          inr;

        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_R", {32'd0, r1}, 64'd0);
        chk("reset_valid", {63'd0, v1}, 64'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        step();
        chk("golden_w1", {32'd0, r1}, 64'hD800_0000);
        check_all("w1");
        step();
        chk("golden_w2", {32'd0, r1}, 64'hDC00_0001);
        check_all("w2");
        for (int i = 3; i <= 100; i++) begin
            step();
            check_all("stream");
            if (i == 7) chk("warm_7", {63'd0, v1}, 64'd0);
            if (i == 8) chk("warm_8", {63'd0, v1}, 64'd1);
        end

        // Enable hold
        hold_r = r1;
        en     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_R", {32'd0, r1}, {32'd0, hold_r});
            check_all("hold");
        end
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_all("resume");
        end

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_R", {32'd0, r1}, 64'd0);
        chk("async_rst_valid", {63'd0, v1}, 64'd0);
        model_reset();
        en = 1'b0;
        step();
        rst_n = 1'b1;

        // Warm-up with a 4-cycle gap: 3 enabled, 4 idle, then enabled until valid
        rise = -1;
        for (int c = 1; c <= 40; c++) begin
            en = (c <= 3 || c >= 8);
            step();
            check_all("gap");
            if (v1 && rise < 0) rise = c;
        end
        chk("gap_valid_rise", 64'(rise), 64'(WARMUP + 4));

        // Random enable pattern from a fresh reset
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
            check_all("rand_en");
        end

        // Long-run statistics
        en   = 1'b1;
        tog  = 32'd0;
        nrep = 0;
        foreach (ones[b]) ones[b] = 0;
        prev = r1;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (m_r !== r1) check_all("long");
            tog = tog | (r1 ^ prev);
            if (r1 == prev) nrep++;
            for (int b = 0; b < 32; b++) if (r1[b]) ones[b]++;
            prev = r1;
        end
        check_all("long_end");
        chk("toggle_all", {32'd0, tog}, 64'hFFFF_FFFF);
        chk("no_repeat", 64'(nrep), 64'd0);
        for (int b = 0; b < 32; b++) begin
            inr = (ones[b] >= 4500) && (ones[b] <= 5500);
            chk($sformatf("ones_frac_bit%0d", b), {63'd0, inr}, 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
